pc_sequencer: RTL and testbench

//   Multi-cycle fetch/decode/resolve controller that owns the program counter.
//   - Fetches each instruction over a req/ready handshake and reads rs/rt from the register file.
//   - Resolves BEQ/BNE/BGT/BGTE/BLE/BLEQ/J/JAL/JR internally; JAL writes the link register.
//   - Hands every other instruction to the execute datapath, then waits for it to finish.

---
 rtl/pc_sequencer_if.sv | 39 +++
 rtl/pc_sequencer.sv | 167 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Signal bundle between the PC sequencer and its environment:
// instruction fetch, register-file read, issue/execute handshake, link write and status.
interface pc_sequencer_if;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned RIDXW = 5;
    localparam int unsigned CNTW  = 16;

    logic             start;
    logic             imem_req;
    logic [XLEN-1:0]  imem_addr;
    logic             imem_ready;
    logic [XLEN-1:0]  imem_rdata;
    logic [RIDXW-1:0] rs_addr;
    logic [RIDXW-1:0] rt_addr;
    logic [XLEN-1:0]  rs_data;
    logic [XLEN-1:0]  rt_data;
    logic             issue_valid;
    logic [XLEN-1:0]  issue_instr;
    logic             ex_busy;
    logic             link_we;
    logic [RIDXW-1:0] link_addr;
    logic [XLEN-1:0]  link_data;
    logic [XLEN-1:0]  pc;
    logic             taken;
    logic [CNTW-1:0]  taken_cnt;
    logic             halted;

    modport master (
        input  start, imem_ready, imem_rdata, rs_data, rt_data, ex_busy,
        output imem_req, imem_addr, rs_addr, rt_addr, issue_valid, issue_instr,
               link_we, link_addr, link_data, pc, taken, taken_cnt, halted
    );

    modport slave (
        output start, imem_ready, imem_rdata, rs_data, rt_data, ex_busy,
        input  imem_req, imem_addr, rs_addr, rt_addr, issue_valid, issue_instr,
               link_we, link_addr, link_data, pc, taken, taken_cnt, halted
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/resolve controller owning the program counter; resolves
// branches and jumps itself and hands all other instructions to the execute datapath.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [4:0]  LINK_REG    = 5'd31,
    parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.master bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned CNTW = 16;

    localparam logic [5:0] OP_JR    = 6'h00;
    localparam logic [5:0] OP_BGTE  = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLE   = 6'h06;
    localparam logic [5:0] OP_BGT   = 6'h07;
    localparam logic [5:0] OP_BLEQ  = 6'h08;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_RESOLVE, S_WAIT, S_LINK, S_HALT
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ir_q, ir_d;
    logic [XLEN-1:0] link_data_q, link_data_d;
    logic [CNTW-1:0] taken_cnt_q, taken_cnt_d;
    logic            imem_req_q, imem_req_d;
    logic            issue_valid_q, issue_valid_d;
    logic            link_we_q, link_we_d;
    logic            halted_q, halted_d;

    logic [5:0]      op;
    logic            is_halt, is_jr, is_ctrl, cond, taken_c;
    logic [XLEN-1:0] pc_inc, off_ext, target;

    assign op      = ir_q[31:26];
    assign pc_inc  = pc_q + 32'd1;
    assign off_ext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign is_halt = (op == HALT_OPCODE);
    assign is_jr   = (op == OP_JR) && (ir_q[5:0] == FUNCT_JR);
    assign is_ctrl = !is_halt &&
                     (is_jr || (op inside {OP_BEQ, OP_BNE, OP_BGT, OP_BGTE,
                                           OP_BLE, OP_BLEQ, OP_J, OP_JAL}));

    // Branch condition (signed compare) and redirect target; JR only reaches here with funct=08
    always_comb begin
        cond   = 1'b0;
        target = pc_inc + off_ext;
        case (op)
            OP_BEQ:  cond = (bus.rs_data == bus.rt_data);
            OP_BNE:  cond = (bus.rs_data != bus.rt_data);
            OP_BGT:  cond = ($signed(bus.rs_data) >  $signed(bus.rt_data));
            OP_BGTE: cond = ($signed(bus.rs_data) >= $signed(bus.rt_data));
            OP_BLE:  cond = ($signed(bus.rs_data) <  $signed(bus.rt_data));
            OP_BLEQ: cond = ($signed(bus.rs_data) <= $signed(bus.rt_data));
            OP_J: begin
                cond   = 1'b1;
                target = {{6{ir_q[25]}}, ir_q[25:0]};
            end
            OP_JAL: begin
                cond   = 1'b1;
                target = {pc_q[31:28], ir_q[25:0], 2'b00};
            end
            OP_JR: begin
                cond   = 1'b1;
                target = bus.rs_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        link_data_d = link_data_q;
        taken_cnt_d = taken_cnt_q;
        taken_c     = 1'b0;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_FETCH;
            S_FETCH: begin
                if (bus.imem_ready) begin
                    ir_d    = bus.imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_RESOLVE;
            S_RESOLVE: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_ctrl) begin
                    taken_c     = cond;
                    pc_d        = cond ? target : pc_inc;
                    taken_cnt_d = taken_cnt_q + CNTW'(cond);
                    if (op == OP_JAL) begin
                        link_data_d = pc_inc;
                        state_d     = S_LINK;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!bus.ex_busy) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_LINK:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
        imem_req_d    = (state_d == S_FETCH);
        link_we_d     = (state_d == S_LINK);
        halted_d      = (state_d == S_HALT);
        // ir is already loaded in DECODE, so the issue pulse can be registered into RESOLVE
        issue_valid_d = (state_q == S_DECODE) && !is_halt && !is_ctrl;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            ir_q          <= '0;
            link_data_q   <= '0;
            taken_cnt_q   <= '0;
            imem_req_q    <= 1'b0;
            issue_valid_q <= 1'b0;
            link_we_q     <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            link_data_q   <= link_data_d;
            taken_cnt_q   <= taken_cnt_d;
            imem_req_q    <= imem_req_d;
            issue_valid_q <= issue_valid_d;
            link_we_q     <= link_we_d;
            halted_q      <= halted_d;
        end
    end

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.rs_addr     = ir_q[25:21];
    assign bus.rt_addr     = ir_q[20:16];
    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_instr = ir_q;
    assign bus.link_we     = link_we_q;
    assign bus.link_addr   = LINK_REG;
    assign bus.link_data   = link_data_q;
    assign bus.pc          = pc_q;
    assign bus.taken       = taken_c;
    assign bus.taken_cnt   = taken_cnt_q;
    assign bus.halted      = halted_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a table of branch/jump vectors plus hand-written
// sequences for JAL linking, execute stalls, fetch stalls, async reset, counter wrap and HALT.
module tb_pc_sequencer;
    localparam logic [5:0] OP_JR   = 6'h00;
    localparam logic [5:0] OP_BGTE = 6'h01;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_BLE  = 6'h06;
    localparam logic [5:0] OP_BGT  = 6'h07;
    localparam logic [5:0] OP_BLEQ = 6'h08;

    typedef struct {
        logic [25:0] start_tgt;
        logic [31:0] instr;
        logic [31:0] rs_v;
        logic [31:0] rt_v;
        logic [31:0] exp_pc;
        logic        exp_taken;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] regs [32];
    logic [15:0] exp_cnt;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_PC   (32'h0000_0000),
        .LINK_REG   (5'd31),
        .HALT_OPCODE(6'h3F)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Register file with one-cycle read latency
    always_ff @(posedge clk) begin
        bus.rs_data <= regs[bus.rs_addr];
        bus.rt_data <= regs[bus.rt_addr];
    end

    function automatic logic [31:0] br(input logic [5:0] op, input logic [15:0] off);
        return {op, 5'd1, 5'd2, off};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] instr);
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.imem_req !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: imem_req got %b expected 1", bus.imem_req);
        end
        bus.imem_rdata = instr;
        bus.imem_ready = 1'b1;
        @(negedge clk);
        bus.imem_ready = 1'b0;
    endtask

    task automatic run_ctrl(input logic [31:0] instr, output logic tk, output logic iv,
                            output logic [31:0] pc_after);
        fetch(instr);
        @(negedge clk);
        tk = bus.taken;
        iv = bus.issue_valid;
        @(negedge clk);
        pc_after = bus.pc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [16];
        logic        tk, iv;
        logic [31:0] pa;
        int          iv_cnt;

        vecs[0]  = '{26'd10,       br(OP_BEQ,  16'h0003), 32'd5,         32'd5,         32'd14,        1'b1};
        vecs[1]  = '{26'd8,        br(OP_BLE,  16'hFFFC), 32'hFFFF_FFFF, 32'd0,         32'd5,         1'b1};
        vecs[2]  = '{26'd8,        br(OP_BLE,  16'hFFFC), 32'd0,         32'd0,         32'd9,         1'b0};
        vecs[3]  = '{26'd20,       br(OP_BNE,  16'h0005), 32'd3,         32'd3,         32'd21,        1'b0};
        vecs[4]  = '{26'd20,       br(OP_BNE,  16'h0005), 32'd3,         32'd4,         32'd26,        1'b1};
        vecs[5]  = '{26'h30,       br(OP_BGT,  16'h0002), 32'd1,         32'hFFFF_FFFF, 32'h33,        1'b1};
        vecs[6]  = '{26'h30,       br(OP_BGT,  16'h0002), 32'd5,         32'd5,         32'h31,        1'b0};
        vecs[7]  = '{26'h40,       br(OP_BGTE, 16'h0010), 32'd5,         32'd5,         32'h51,        1'b1};
        vecs[8]  = '{26'h40,       br(OP_BGTE, 16'h0010), 32'hFFFF_FFFE, 32'd1,         32'h41,        1'b0};
        vecs[9]  = '{26'd100,      br(OP_BLEQ, 16'hFFFF), 32'd7,         32'd7,         32'd100,       1'b1};
        vecs[10] = '{26'd100,      br(OP_BLEQ, 16'hFFFF), 32'd8,         32'd7,         32'd101,       1'b0};
        vecs[11] = '{26'd200,      br(OP_BEQ,  16'h0001), 32'h8000_0000, 32'h7FFF_FFFF, 32'd201,       1'b0};
        vecs[12] = '{26'h3FF_FFFF, br(OP_BEQ,  16'h0000), 32'd1,         32'd1,         32'd0,         1'b1};
        vecs[13] = '{26'd5,        {OP_J, 26'h3FF_FFF0},  32'd0,         32'd0,         32'hFFFF_FFF0, 1'b1};
        vecs[14] = '{26'd7,        {OP_JR, 5'd1, 15'd0, 6'h08}, 32'h1234_5678, 32'd0,  32'h1234_5678, 1'b1};
        vecs[15] = '{26'd9,        br(OP_BGT,  16'h0004), 32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'd10,        1'b0};

        for (int r = 0; r < 32; r++) regs[r] = 32'd0;
        bus.start      = 1'b0;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'd0;
        bus.ex_busy    = 1'b0;
        exp_cnt        = 16'd0;

        // Reset values
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_pc", bus.pc, 32'd0);
        chk("rst_taken_cnt", 32'(bus.taken_cnt), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_no_req", 32'(bus.imem_req), 32'd0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_req", 32'(bus.imem_req), 32'd1);
        chk("start_addr", bus.imem_addr, 32'd0);

        // Branch/jump vectors, each preceded by a J to the start pc
        for (int i = 0; i < 16; i++) begin
            regs[1] = vecs[i].rs_v;
            regs[2] = vecs[i].rt_v;
            run_ctrl({OP_J, vecs[i].start_tgt}, tk, iv, pa);
            exp_cnt++;
            run_ctrl(vecs[i].instr, tk, iv, pa);
            chk($sformatf("vec%0d_pc", i), pa, vecs[i].exp_pc);
            chk($sformatf("vec%0d_taken", i), 32'(tk), 32'(vecs[i].exp_taken));
            chk($sformatf("vec%0d_no_issue", i), 32'(iv), 32'd0);
            if (vecs[i].exp_taken) exp_cnt++;
        end
        chk("taken_cnt_after_vectors", 32'(bus.taken_cnt), 32'(exp_cnt));

        // JAL: redirect, then a one-cycle link write of pc+1
        regs[1] = 32'h1000_0007;
        run_ctrl({OP_JR, 5'd1, 15'd0, 6'h08}, tk, iv, pa);
        exp_cnt++;
        chk("jr_pc", pa, 32'h1000_0007);
        fetch({OP_JAL, 26'h000_0040});
        @(negedge clk);
        chk("jal_taken", 32'(bus.taken), 32'd1);
        chk("jal_no_link_yet", 32'(bus.link_we), 32'd0);
        @(negedge clk);
        exp_cnt++;
        chk("jal_pc", bus.pc, 32'h1000_0100);
        chk("jal_link_we", 32'(bus.link_we), 32'd1);
        chk("jal_link_addr", 32'(bus.link_addr), 32'd31);
        chk("jal_link_data", bus.link_data, 32'h1000_0008);
        chk("jal_no_req_in_link", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        chk("jal_link_we_drop", 32'(bus.link_we), 32'd0);
        chk("jal_refetch", 32'(bus.imem_req), 32'd1);

        // Non-control instruction with execute busy for 4 cycles
        bus.ex_busy = 1'b1;
        fetch({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20});
        @(negedge clk);
        chk("alu_issue", 32'(bus.issue_valid), 32'd1);
        chk("alu_no_taken", 32'(bus.taken), 32'd0);
        chk("alu_issue_instr", bus.issue_instr, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20});
        iv_cnt = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.issue_valid === 1'b1) iv_cnt++;
            chk($sformatf("busy%0d_pc", c), bus.pc, 32'h1000_0100);
            chk($sformatf("busy%0d_no_req", c), 32'(bus.imem_req), 32'd0);
        end
        bus.ex_busy = 1'b0;
        @(negedge clk);
        chk("alu_pc_inc", bus.pc, 32'h1000_0101);
        chk("alu_refetch", 32'(bus.imem_req), 32'd1);
        chk("alu_issue_once", 32'(iv_cnt), 32'd1);
        chk("alu_taken_cnt_unchanged", 32'(bus.taken_cnt), 32'(exp_cnt));

        // Non-control instruction with execute already idle
        fetch({6'h23, 26'd0});
        @(negedge clk);
        chk("alu2_issue", 32'(bus.issue_valid), 32'd1);
        @(negedge clk);
        chk("alu2_issue_drop", 32'(bus.issue_valid), 32'd0);
        chk("alu2_pc_wait", bus.pc, 32'h1000_0101);
        @(negedge clk);
        chk("alu2_pc_inc", bus.pc, 32'h1000_0102);

        // Fetch stall, then async reset in the middle of it
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_req", c), 32'(bus.imem_req), 32'd1);
            chk($sformatf("stall%0d_addr", c), bus.imem_addr, 32'h1000_0102);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req", 32'(bus.imem_req), 32'd0);
        chk("async_rst_pc", bus.pc, 32'd0);
        chk("async_rst_cnt", 32'(bus.taken_cnt), 32'd0);
        exp_cnt = 16'd0;
        bus.imem_rdata = {6'h3F, 26'd0};
        bus.imem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("late_ready_ignored_req", 32'(bus.imem_req), 32'd0);
        chk("late_ready_ignored_halt", 32'(bus.halted), 32'd0);
        chk("late_ready_ignored_pc", bus.pc, 32'd0);
        bus.imem_ready = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("restart_req", 32'(bus.imem_req), 32'd1);

        // Redirect counter wrap, preloaded near the top
        force dut.taken_cnt_q = 16'hFFFE;
        #1 release dut.taken_cnt_q;
        exp_cnt = 16'hFFFE;
        run_ctrl({OP_J, 26'd3}, tk, iv, pa);
        exp_cnt++;
        chk("wrap_cnt_ffff", 32'(bus.taken_cnt), 32'(exp_cnt));
        run_ctrl({OP_J, 26'd5}, tk, iv, pa);
        exp_cnt++;
        chk("wrap_cnt_zero", 32'(bus.taken_cnt), 32'(exp_cnt));
        chk("wrap_pc", pa, 32'd5);

        // HALT freezes the PC; start is ignored
        fetch({6'h3F, 26'd0});
        @(negedge clk);
        chk("halt_not_yet", 32'(bus.halted), 32'd0);
        @(negedge clk);
        chk("halted", 32'(bus.halted), 32'd1);
        chk("halt_pc", bus.pc, 32'd5);
        bus.start = 1'b1;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        chk("halt_sticky", 32'(bus.halted), 32'd1);
        chk("halt_no_req", 32'(bus.imem_req), 32'd0);
        chk("halt_pc_frozen", bus.pc, 32'd5);
        chk("halt_no_taken", 32'(bus.taken), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
